// File: rtl/sideways_memory_mapper_if.sv
// Bus bundle between the memory mapper, the 6502/video side and the RAM/ROM arrays.
// The slave modport is the mapper; the master modport is the system (or testbench) side.
interface sideways_memory_mapper_if #(
    parameter int BANK_BITS = 4,
    parameter int VID_AW    = 15
);
    // Handshakes: cpu_rvalid/vid_valid are one-cycle pulses that carry no back-pressure.
    // cpu_ready is high when the write buffer is empty; a write is taken only on
    // proc_en & ~cpu_rnw while cpu_ready is high, otherwise the CPU must hold it.
    logic                 ram_en;
    logic                 v_turn;
    logic                 proc_en;
    logic [15:0]          cpu_addr;
    logic                 cpu_rnw;
    logic [7:0]           cpu_wdata;
    logic                 romsel_wr;
    logic [7:0]           cpu_rdata;
    logic                 cpu_rvalid;
    logic                 cpu_ready;
    logic [VID_AW-1:0]    vid_addr;
    logic [7:0]           vid_data;
    logic                 vid_valid;
    logic [BANK_BITS-1:0] rom_bank;
    logic [1:0]           mem_sel;
    logic [14:0]          mem_addr;
    logic                 mem_we;
    logic [7:0]           mem_wdata;
    logic [7:0]           mem_rdata;

    modport slave (
        input  ram_en, v_turn, proc_en, cpu_addr, cpu_rnw, cpu_wdata, romsel_wr,
               vid_addr, mem_rdata,
        output cpu_rdata, cpu_rvalid, cpu_ready, vid_data, vid_valid, rom_bank,
               mem_sel, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output ram_en, v_turn, proc_en, cpu_addr, cpu_rnw, cpu_wdata, romsel_wr,
               vid_addr, mem_rdata,
        input  cpu_rdata, cpu_rvalid, cpu_ready, vid_data, vid_valid, rom_bank,
               mem_sel, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/sideways_memory_mapper.sv
// CPU/video memory mapper with ROMSEL latch, slot arbitration and a one-entry write buffer.
// Optional feature macro: SWRAM_WRITE_EN enables writes into sideways RAM banks.
module sideways_memory_mapper #(
    parameter int          BANK_BITS  = 4,
    parameter int          ROM_BANKS  = 4,
    parameter logic [15:0] SWRAM_MASK = 16'h0000,
    parameter int          VID_AW     = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    sideways_memory_mapper_if.slave bus,
    output logic [1:0]              wb_state_o
);
    typedef enum logic [1:0] {WB_EMPTY, WB_FULL, WB_COMMIT} wb_state_e;
    typedef enum logic [1:0] {RD_NONE, RD_VID, RD_CPU, RD_FF} rd_kind_e;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_RAM  = 2'd1;
    localparam logic [1:0] SEL_OS   = 2'd2;
    localparam logic [1:0] SEL_BANK = 2'd3;

    // Without the feature every bank is treated as read-only.
    localparam logic [15:0] WR_MASK =
`ifdef SWRAM_WRITE_EN
        SWRAM_MASK;
`else
        SWRAM_MASK & 16'h0000;
`endif

    logic [BANK_BITS-1:0] rom_bank_q, rom_bank_d;
    wb_state_e            wb_state_q, wb_state_d;
    logic [1:0]           wb_sel_q, wb_sel_d;
    logic [14:0]          wb_addr_q, wb_addr_d;
    logic [7:0]           wb_data_q, wb_data_d;
    logic [1:0]           mem_sel_q, mem_sel_d;
    logic [14:0]          mem_addr_q, mem_addr_d;
    logic                 mem_we_q, mem_we_d;
    logic [7:0]           mem_wdata_q, mem_wdata_d;
    rd_kind_e             rd_kind_q, rd_kind_d;
    logic [7:0]           cpu_rdata_q, cpu_rdata_d;
    logic                 cpu_rvalid_q, cpu_rvalid_d;
    logic [7:0]           vid_data_q, vid_data_d;
    logic                 vid_valid_q, vid_valid_d;

    logic [VID_AW-1:0]    vid_a;
    logic [15:0]          a;
    logic [31:0]          bank_idx;
    logic                 bank_populated;
    logic                 bank_writable;
    logic [1:0]           dec_sel;
    logic [14:0]          dec_addr;
    logic                 dec_io;
    logic                 dec_ff;
    logic                 dec_wr_ok;

    assign vid_a          = bus.vid_addr;
    assign a              = bus.cpu_addr;
    assign bank_idx       = 32'(rom_bank_q);
    assign bank_populated = bank_idx < 32'(ROM_BANKS);
    assign bank_writable  = (bank_idx < 32'd16) && WR_MASK[bank_idx[3:0]];

    always_comb begin
        dec_sel   = SEL_NONE;
        dec_addr  = '0;
        dec_io    = 1'b0;
        dec_ff    = 1'b0;
        dec_wr_ok = 1'b0;
        if (!a[15]) begin
            dec_sel   = SEL_RAM;
            dec_addr  = a[14:0];
            dec_wr_ok = 1'b1;
        end else if (a[15:14] == 2'b10) begin
            dec_addr  = {1'b0, a[13:0]};
            dec_wr_ok = bank_writable;
            if (bank_populated) dec_sel = SEL_BANK;
            else                dec_ff  = 1'b1;
        end else if (a >= 16'hFC00 && a <= 16'hFEFF) begin
            dec_io = 1'b1;
        end else begin
            dec_sel  = SEL_OS;
            dec_addr = {1'b0, a[13:0]};
        end
    end

    always_comb begin
        rom_bank_d   = rom_bank_q;
        wb_state_d   = wb_state_q;
        wb_sel_d     = wb_sel_q;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;
        mem_sel_d    = SEL_NONE;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        rd_kind_d    = RD_NONE;
        cpu_rdata_d  = cpu_rdata_q;
        cpu_rvalid_d = 1'b0;
        vid_data_d   = vid_data_q;
        vid_valid_d  = 1'b0;

        // A ROMSEL write lands after this cycle's slot has used the old bank.
        if (bus.proc_en && bus.romsel_wr) rom_bank_d = bus.cpu_wdata[BANK_BITS-1:0];

        case (wb_state_q)
            WB_EMPTY: begin
                if (bus.proc_en && !bus.cpu_rnw && dec_wr_ok) begin
                    wb_sel_d   = a[15] ? SEL_BANK : SEL_RAM;
                    wb_addr_d  = a[15] ? {1'b0, a[13:0]} : a[14:0];
                    wb_data_d  = bus.cpu_wdata;
                    wb_state_d = WB_FULL;
                end
            end
            WB_FULL: begin
                if (bus.ram_en && !bus.v_turn) begin
                    mem_sel_d   = wb_sel_q;
                    mem_addr_d  = wb_addr_q;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = wb_data_q;
                    wb_state_d  = WB_COMMIT;
                end
            end
            WB_COMMIT: wb_state_d = WB_EMPTY;
            default:   wb_state_d = WB_EMPTY;
        endcase

        if (bus.ram_en && bus.v_turn) begin
            mem_sel_d  = SEL_RAM;
            mem_addr_d = 15'(vid_a);
            rd_kind_d  = RD_VID;
        end else if (bus.ram_en && wb_state_q != WB_FULL && bus.cpu_rnw && !dec_io) begin
            if (dec_ff) begin
                rd_kind_d = RD_FF;
            end else begin
                mem_sel_d  = dec_sel;
                mem_addr_d = dec_addr;
                rd_kind_d  = RD_CPU;
            end
        end

        // Second pipeline stage: the array data sampled here was addressed last cycle.
        case (rd_kind_q)
            RD_VID: begin vid_data_d = bus.mem_rdata; vid_valid_d = 1'b1; end
            RD_CPU: begin cpu_rdata_d = bus.mem_rdata; cpu_rvalid_d = 1'b1; end
            RD_FF:  begin cpu_rdata_d = 8'hFF; cpu_rvalid_d = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_bank_q   <= '0;
            wb_state_q   <= WB_EMPTY;
            wb_sel_q     <= SEL_NONE;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            mem_sel_q    <= SEL_NONE;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            rd_kind_q    <= RD_NONE;
            cpu_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            vid_data_q   <= '0;
            vid_valid_q  <= 1'b0;
        end else begin
            rom_bank_q   <= rom_bank_d;
            wb_state_q   <= wb_state_d;
            wb_sel_q     <= wb_sel_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            mem_sel_q    <= mem_sel_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            rd_kind_q    <= rd_kind_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            vid_data_q   <= vid_data_d;
            vid_valid_q  <= vid_valid_d;
        end
    end

    assign bus.rom_bank   = rom_bank_q;
    assign bus.mem_sel    = mem_sel_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.cpu_ready  = (wb_state_q == WB_EMPTY);
    assign bus.vid_data   = vid_data_q;
    assign bus.vid_valid  = vid_valid_q;
    assign wb_state_o     = wb_state_q;
endmodule

// File: tb/tb_sideways_memory_mapper.sv
// Directed bench for sideways_memory_mapper: decode, slot timing, write buffer, ROMSEL and reset.
module tb_sideways_memory_mapper;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] wb_state;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  sideways_memory_mapper_if #(.BANK_BITS(4), .VID_AW(15)) bus ();

  sideways_memory_mapper #(
    .BANK_BITS(4), .ROM_BANKS(4), .SWRAM_MASK(16'h0002), .VID_AW(15)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .wb_state_o(wb_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.ram_en = 1'b0; bus.v_turn = 1'b0; bus.proc_en = 1'b0; bus.romsel_wr = 1'b0;
    bus.cpu_rnw = 1'b1;
  endtask

  // Drive one slot for a cycle; returns at T+1.
  task automatic slot(input logic vid, input logic [15:0] ca, input logic [14:0] va);
    bus.ram_en = 1'b1; bus.v_turn = vid; bus.cpu_addr = ca; bus.vid_addr = va;
    bus.cpu_rnw = 1'b1;
    tick();
    bus.ram_en = 1'b0;
  endtask

  // CPU write offered for one cycle; returns the cycle after.
  task automatic cpu_write(input logic [15:0] ca, input logic [7:0] wd);
    bus.proc_en = 1'b1; bus.cpu_rnw = 1'b0; bus.cpu_addr = ca; bus.cpu_wdata = wd;
    tick();
    bus.proc_en = 1'b0; bus.cpu_rnw = 1'b1;
  endtask

  task automatic check_cpu_read(input string tag);
    logic [7:0] e;
    check({tag, "_rvalid"}, 32'(bus.cpu_rvalid), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    check({tag, "_rdata"}, 32'(bus.cpu_rdata), 32'(e));
  endtask

  initial begin
    reset = 1'b1;
    idle();
    bus.cpu_addr = 16'h0000; bus.cpu_wdata = 8'h00; bus.vid_addr = 15'h0;
    bus.mem_rdata = 8'h00;
    tick(); tick();

    check("rst_rom_bank", 32'(bus.rom_bank), 32'h0);
    check("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'h00);
    check("rst_vid_data", 32'(bus.vid_data), 32'h00);
    check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
    check("rst_vid_valid", 32'(bus.vid_valid), 32'h0);
    check("rst_mem_we", 32'(bus.mem_we), 32'h0);
    check("rst_mem_sel", 32'(bus.mem_sel), 32'h0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
    check("rst_cpu_ready", 32'(bus.cpu_ready), 32'h1);
    reset = 1'b0;
    tick();

    // OS ROM read at 0xC000
    slot(1'b0, 16'hC000, 15'h0);
    check("os_sel", 32'(bus.mem_sel), 32'd2);
    check("os_addr", 32'(bus.mem_addr), 32'h0000);
    check("os_rvalid_t1", 32'(bus.cpu_rvalid), 32'd0);
    bus.mem_rdata = 8'h3C; exp_q.push_back(8'h3C);
    tick();
    check_cpu_read("os");
    bus.mem_rdata = 8'h00;
    tick();
    check("os_rvalid_pulse", 32'(bus.cpu_rvalid), 32'd0);
    check("os_rdata_hold", 32'(bus.cpu_rdata), 32'h3C);
    check("os_sel_idle", 32'(bus.mem_sel), 32'd0);

    // Video fetch
    slot(1'b1, 16'h0000, 15'h3ABC);
    check("vid_sel", 32'(bus.mem_sel), 32'd1);
    check("vid_addr", 32'(bus.mem_addr), 32'h3ABC);
    bus.mem_rdata = 8'h77;
    tick();
    check("vid_valid", 32'(bus.vid_valid), 32'd1);
    check("vid_data", 32'(bus.vid_data), 32'h77);
    check("vid_no_cpu_valid", 32'(bus.cpu_rvalid), 32'd0);
    tick();

    // Buffered main-RAM write
    cpu_write(16'h1234, 8'h5A);
    check("wr_ready_low", 32'(bus.cpu_ready), 32'd0);
    check("wr_state_full", 32'(wb_state), 32'd1);
    slot(1'b1, 16'h0000, 15'h0000);
    check("wr_vid_no_we", 32'(bus.mem_we), 32'd0);
    check("wr_vid_ready", 32'(bus.cpu_ready), 32'd0);
    slot(1'b0, 16'h1234, 15'h0);
    check("wr_we", 32'(bus.mem_we), 32'd1);
    check("wr_addr", 32'(bus.mem_addr), 32'h1234);
    check("wr_data", 32'(bus.mem_wdata), 32'h5A);
    check("wr_sel", 32'(bus.mem_sel), 32'd1);
    check("wr_ready_t1", 32'(bus.cpu_ready), 32'd0);
    tick();
    check("wr_we_pulse", 32'(bus.mem_we), 32'd0);
    check("wr_ready_t2", 32'(bus.cpu_ready), 32'd1);
    check("wr_no_rvalid", 32'(bus.cpu_rvalid), 32'd0);

    // Write to OS ROM is dropped
    cpu_write(16'hC000, 8'h11);
    check("os_wr_dropped", 32'(bus.cpu_ready), 32'd1);

    // ROMSEL=7, unpopulated bank reads 0xFF
    bus.romsel_wr = 1'b1;
    cpu_write(16'hFE30, 8'h07);
    bus.romsel_wr = 1'b0;
    check("romsel7", 32'(bus.rom_bank), 32'h7);
    check("romsel_io_wr_dropped", 32'(bus.cpu_ready), 32'd1);
    slot(1'b0, 16'h8000, 15'h0);
    check("unpop_sel", 32'(bus.mem_sel), 32'd0);
    bus.mem_rdata = 8'h12; exp_q.push_back(8'hFF);
    tick();
    check_cpu_read("unpop");

    // ROMSEL=1 in the same cycle as a slot: old bank 7 still used for that slot
    bus.proc_en = 1'b1; bus.romsel_wr = 1'b1; bus.cpu_wdata = 8'h01;
    slot(1'b0, 16'h8000, 15'h0);
    bus.proc_en = 1'b0; bus.romsel_wr = 1'b0;
    check("same_slot_sel", 32'(bus.mem_sel), 32'd0);
    check("same_slot_bank", 32'(bus.rom_bank), 32'h1);
    exp_q.push_back(8'hFF);
    tick();
    check_cpu_read("same_slot");
    slot(1'b0, 16'h8000, 15'h0);
    check("bank1_sel", 32'(bus.mem_sel), 32'd3);
    check("bank1_addr", 32'(bus.mem_addr), 32'h0000);
    bus.mem_rdata = 8'h11; exp_q.push_back(8'h11);
    tick();
    check_cpu_read("bank1");

    // I/O read: no access, no capture
    slot(1'b0, 16'hFC10, 15'h0);
    check("io_sel", 32'(bus.mem_sel), 32'd0);
    bus.mem_rdata = 8'hEE;
    tick();
    check("io_no_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    check("io_rdata_hold", 32'(bus.cpu_rdata), 32'h11);

    // Sideways RAM write into bank 1
    cpu_write(16'h9000, 8'hA5);
`ifdef SWRAM_WRITE_EN
    check("sw_ready_low", 32'(bus.cpu_ready), 32'd0);
    slot(1'b0, 16'h9000, 15'h0);
    check("sw_we", 32'(bus.mem_we), 32'd1);
    check("sw_sel", 32'(bus.mem_sel), 32'd3);
    check("sw_addr", 32'(bus.mem_addr), 32'h1000);
    check("sw_data", 32'(bus.mem_wdata), 32'hA5);
    tick();
    check("sw_ready_back", 32'(bus.cpu_ready), 32'd1);
`else
    check("sw_ready_stays", 32'(bus.cpu_ready), 32'd1);
    slot(1'b0, 16'h9000, 15'h0);
    check("sw_no_we", 32'(bus.mem_we), 32'd0);
    tick();
`endif

    // Back-to-back video then CPU slots
    bus.ram_en = 1'b1; bus.v_turn = 1'b1; bus.vid_addr = 15'h0123;
    tick();
    bus.v_turn = 1'b0; bus.cpu_addr = 16'h0456; bus.cpu_rnw = 1'b1;
    check("b2b_vid_sel", 32'(bus.mem_sel), 32'd1);
    check("b2b_vid_addr", 32'(bus.mem_addr), 32'h0123);
    bus.mem_rdata = 8'h44;
    tick();
    bus.ram_en = 1'b0;
    check("b2b_vid_valid", 32'(bus.vid_valid), 32'd1);
    check("b2b_vid_data", 32'(bus.vid_data), 32'h44);
    check("b2b_cpu_sel", 32'(bus.mem_sel), 32'd1);
    check("b2b_cpu_addr", 32'(bus.mem_addr), 32'h0456);
    bus.mem_rdata = 8'h55; exp_q.push_back(8'h55);
    tick();
    check_cpu_read("b2b_cpu");
    check("b2b_vid_pulse", 32'(bus.vid_valid), 32'd0);

    // Reset the cycle after a write is accepted, with a CPU slot offered
    cpu_write(16'h0100, 8'h99);
    check("rstmid_ready_low", 32'(bus.cpu_ready), 32'd0);
    reset = 1'b1;
    slot(1'b0, 16'h0100, 15'h0);
    reset = 1'b0;
    check("rstmid_no_we", 32'(bus.mem_we), 32'd0);
    check("rstmid_ready", 32'(bus.cpu_ready), 32'd1);
    check("rstmid_bank", 32'(bus.rom_bank), 32'h0);
    tick();
    check("rstmid_no_we2", 32'(bus.mem_we), 32'd0);
    check("rstmid_no_rvalid", 32'(bus.cpu_rvalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
